// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target that collects 3-byte codec
// configuration words [SLAVE_ADDR, SUB_ADDR, DATA] and presents each complete
// word as a 24-bit value with a one-cycle strobe.
//
// Ports:
//   CLOCK31_5    in   system clock
//   RESET        in   asynchronous, active-low reset
//   I2C_SCLK     in   bus clock from the master
//   I2C_SDAT_IN  in   bus data as seen on the wire
//   SDA_OE       out  1 = pull SDA low (ACK); pad is open-drain
//   WORD_VALID   out  one-cycle pulse per acknowledged 3-byte write
//   WORD_DATA    out  {addr byte, sub byte, data byte}, held between strobes
//   ABORT        out  one-cycle pulse when an addressed write ends early
//   BUSY         out  high from address match until STOP / repeated START
module i2c_codec_target #(
    parameter logic [6:0]  TARGET_ADDR = 7'h1A,
    parameter int unsigned MIN_PHASE   = 8
) (
    input  logic        CLOCK31_5,
    input  logic        RESET,
    input  logic        I2C_SCLK,
    input  logic        I2C_SDAT_IN,
    output logic        SDA_OE,
    output logic        WORD_VALID,
    output logic [23:0] WORD_DATA,
    output logic        ABORT,
    output logic        BUSY
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_SUB, S_ACK_SUB,
        S_DATA, S_ACK_DATA, S_HOLD, S_IGNORE
    } state_t;

    // [0],[1] synchronizer stages, [2] previous synchronized value
    logic [2:0]  scl_q, sda_q;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic        ack_on_q, ack_on_d;   // second half of an ACK slot
    logic        sda_oe_q, sda_oe_d;
    logic        wvalid_q, wvalid_d;
    logic        abort_q, abort_d;
    logic [23:0] word_q, word_d;

    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0] full_byte;
    logic abortable;

    assign scl_s    = scl_q[1];
    assign scl_p    = scl_q[2];
    assign sda_s    = sda_q[1];
    assign sda_p    = sda_q[2];
    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    // SCL must be high in both samples so an SDA change racing an SCL edge
    // is never taken for a bus condition.
    assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;
    assign full_byte = {sh_q[6:0], sda_s};

    // An addressed write that has not yet produced its word.
    assign abortable = (state_q == S_ACK_ADDR) || (state_q == S_SUB) ||
                       (state_q == S_ACK_SUB)  || (state_q == S_DATA) ||
                       ((state_q == S_ACK_DATA) && !ack_on_q);

    always_ff @(posedge CLOCK31_5 or negedge RESET) begin
        if (!RESET) begin
            scl_q    <= 3'b111;   // idle bus reads high
            sda_q    <= 3'b111;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            ack_on_q <= 1'b0;
            sda_oe_q <= 1'b0;
            wvalid_q <= 1'b0;
            abort_q  <= 1'b0;
            word_q   <= '0;
        end else begin
            scl_q    <= {scl_q[1:0], I2C_SCLK};
            sda_q    <= {sda_q[1:0], I2C_SDAT_IN};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            ack_on_q <= ack_on_d;
            sda_oe_q <= sda_oe_d;
            wvalid_q <= wvalid_d;
            abort_q  <= abort_d;
            word_q   <= word_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        ack_on_d = ack_on_q;
        if (start_ev) begin
            state_d  = S_ADDR;
            cnt_d    = '0;
            idx_d    = '0;
            sh_d     = '0;
            ack_on_d = 1'b0;
        end else if (stop_ev) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            ack_on_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_SUB, S_DATA: begin
                    if (scl_rise) begin
                        sh_d  = full_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (idx_q == 2'd0) b0_d = full_byte;
                            if (idx_q == 2'd1) b1_d = full_byte;
                            idx_d = idx_q + 2'd1;
                            case (state_q)
                                S_ADDR:  state_d = (full_byte == {TARGET_ADDR, 1'b0})
                                                   ? S_ACK_ADDR : S_IGNORE;
                                S_SUB:   state_d = S_ACK_SUB;
                                default: state_d = S_ACK_DATA;
                            endcase
                        end
                    end
                end
                S_ACK_ADDR, S_ACK_SUB, S_ACK_DATA: begin
                    // First fall (end of bit 8) drives ACK, second fall
                    // (end of 9th clock) releases it and moves on.
                    if (scl_fall) begin
                        ack_on_d = ~ack_on_q;
                        if (ack_on_q) begin
                            case (state_q)
                                S_ACK_ADDR: state_d = S_SUB;
                                S_ACK_SUB:  state_d = S_DATA;
                                default:    state_d = S_HOLD;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe_d = sda_oe_q;
        wvalid_d = 1'b0;
        abort_d  = 1'b0;
        word_d   = word_q;
        BUSY     = (state_q == S_ACK_ADDR) || (state_q == S_SUB) ||
                   (state_q == S_ACK_SUB)  || (state_q == S_DATA) ||
                   (state_q == S_ACK_DATA) || (state_q == S_HOLD);
        if (start_ev || stop_ev) begin
            sda_oe_d = 1'b0;
            abort_d  = abortable;
        end else begin
            case (state_q)
                S_ACK_ADDR, S_ACK_SUB, S_ACK_DATA: begin
                    if (scl_fall) begin
                        sda_oe_d = ~ack_on_q;
                        if ((state_q == S_ACK_DATA) && !ack_on_q) begin
                            wvalid_d = 1'b1;
                            word_d   = {b0_q, b1_q, sh_q};
                        end
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign SDA_OE     = sda_oe_q;
    assign WORD_VALID = wvalid_q;
    assign ABORT      = abort_q;
    assign WORD_DATA  = word_q;

`ifndef SYNTHESIS
    // Flags SCL phases shorter than the supported minimum.
    logic [7:0] phase_q;
    logic       phase_seen_q;
    always_ff @(posedge CLOCK31_5 or negedge RESET) begin
        if (!RESET) begin
            phase_q      <= '0;
            phase_seen_q <= 1'b0;
        end else if (scl_rise || scl_fall) begin
            phase_q      <= '0;
            phase_seen_q <= 1'b1;
        end else if (phase_q != 8'hFF) begin
            phase_q <= phase_q + 8'd1;
        end
    end
    a_min_phase: assert property (@(posedge CLOCK31_5) disable iff (!RESET)
        ((scl_rise || scl_fall) && phase_seen_q) |-> (32'(phase_q) + 32'd1 >= MIN_PHASE));
`endif
endmodule

// File: doc/i2c_codec_target.md
# i2c_codec_target

I2C write-only target (slave) that receives 3-byte codec configuration words. The word format is [SLAVE_ADDR, SUB_ADDR, DATA], the same as the format the audio codec controller's I2C master emits. It sits in the audio codec controller as an on-chip codec register model for simulation and loop-back bring-up. Each complete word is presented as a 24-bit value with a one-cycle strobe.

## Interface
Parameters:
- TARGET_ADDR, 7'h1A, 7-bit device address answered (write byte 0x34).
- MIN_PHASE, 8, minimum SCL high/low duration accepted, in CLOCK31_5 cycles (documentation/assertion only).

Ports:
- CLOCK31_5  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- I2C_SCLK  in  1  bus clock from the master.
- I2C_SDAT_IN  in  1  bus data as seen on the wire.
- SDA_OE  out  1  1 = pull SDA low (ACK). Open-drain: the pad drives 0 when 1 and Z otherwise.
- WORD_VALID  out  1  one-cycle pulse when a full 3-byte write has been acknowledged.
- WORD_DATA  out  24  {addr byte, sub byte, data byte}. Held until the next WORD_VALID.
- ABORT  out  1  one-cycle pulse: addressed transaction ended by STOP/START before 3 bytes.
- BUSY  out  1  1 from an address-matched START until STOP/repeated START.

## Operation
- Input conditioning:
  - I2C_SCLK and I2C_SDAT_IN each pass through a 2-FF synchronizer.
  - A third register per line gives the previous value for edge detection.
- Event detection, on synchronized values:
  - scl_rise / scl_fall: SCL edges.
  - START: SDA 1->0 while SCL==1.
  - STOP: SDA 0->1 while SCL==1.
  - START/STOP take priority over bit sampling in the same cycle.
- Bit counter: 3 bits, plus a byte index 0..2.
  - Data is sampled on scl_rise, MSB first, into an 8-bit shift register.
  - After the 8th scl_rise the byte is complete.
- States and transitions:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits. At byte complete:
    - byte == {TARGET_ADDR,1'b0}: go to ACK_ADDR.
    - otherwise (wrong address or R/W=1): go to IGNORE.
  - ACK_ADDR: assert SDA_OE at the next scl_fall. Deassert it at the following scl_fall, then go to SUB. BUSY=1.
  - SUB: shift 8 bits, go to ACK_SUB. ACK_SUB handles the ACK exactly as ACK_ADDR, then goes to DATA.
  - DATA: shift 8 bits, go to ACK_DATA.
    - At the scl_fall where SDA_OE asserts, load WORD_DATA and pulse WORD_VALID.
    - SDA_OE releases at the next scl_fall, then go to HOLD.
  - HOLD: further bytes are not acknowledged (SDA_OE stays 0). Wait for STOP or START.
  - IGNORE: SDA_OE=0. Wait for STOP or START.
- STOP in any state: go to IDLE and release SDA_OE in the same cycle.
  - Pulse ABORT if the state is in ACK_ADDR..ACK_DATA before WORD_VALID has fired.
- START in any state other than IDLE (repeated START): go to ADDR, clear the counters, release SDA_OE.
  - ABORT rules are the same as for STOP.
- WORD_DATA byte order: [23:16] address byte (including R/W=0), [15:8] sub-address, [7:0] data.

## Timing
- Reset values:
  - SDA_OE=0, WORD_VALID=0, ABORT=0, BUSY=0, WORD_DATA=24'h0, state IDLE.
  - Reset is asynchronous, so SDA_OE releases immediately, including mid-byte.
- Input-to-event latency: 3 CLOCK31_5 cycles (2 sync + edge register).
- SDA_OE asserts 1 cycle after the detected scl_fall ending bit 8, and deasserts 1 cycle after the scl_fall ending the 9th clock.
  - This guarantees SDA changes only while SCL is low.
- WORD_VALID is asserted in the same cycle as the ACK_DATA SDA_OE assertion, for exactly 1 cycle.
- ABORT is 1 cycle wide. WORD_VALID and ABORT are never high together.
- SCL high/low phases shorter than MIN_PHASE cycles are out of spec; behaviour is undefined.
- No ACK is driven on the 9th clock after a non-matching address.

## Test plan
- Write 0x34,0x1E,0x00 with STOP:
  - ACK (SDA_OE pulse) on all three 9th clocks.
  - WORD_VALID once, WORD_DATA=24'h341E00, BUSY falls after STOP.
- Address 0x36 then two bytes:
  - SDA_OE never asserts, no WORD_VALID, no ABORT.
- Read request 0x35: no ACK, state IGNORE until STOP, no outputs.
- 0x34,0x0C then STOP:
  - two ACKs, ABORT pulse, no WORD_VALID, WORD_DATA unchanged from prior word.
- Repeated START after 0x34,0x04, then full 0x34,0x08,0x12:
  - ABORT once, then WORD_VALID with 24'h340812.
- RESET low during the SUB-byte ACK: SDA_OE drops asynchronously.
  - After release, the next full write (0x34,0x10,0x55) yields 24'h341055.
